// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: assembles 32-bit little-endian words from an 8-bit synchronous memory.
// Optional byte loader port and LOAD state are present only when IMEM_LOADER_EN is defined.
module imem_fetch_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = 2048,
   parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ready,
   output logic                  fetch_valid,
   output logic [31:0]           fetch_instr,
   output logic                  fetch_err,
`ifdef IMEM_LOADER_EN
   input  logic                  load_req,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [7:0]            load_data,
   output logic                  load_ack,
`endif
   output logic [MEM_AW-1:0]     mem_addr,
   input  logic [7:0]            mem_rdata,
   output logic                  mem_we,
   output logic [7:0]            mem_wdata
);

   localparam logic [31:0]           NOP_INSTR = 32'h0000_0013;
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_DEPTH - 4);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DRAIN,
      RESP
`ifdef IMEM_LOADER_EN
      , LOAD
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [MEM_AW-1:0] base_q, base_d;
   logic [23:0]       asm_q, asm_d;
   logic [31:0]       instr_q, instr_d;
   logic              err_q, err_d;
   logic              fetch_bad;
   logic              load_pending;

`ifdef IMEM_LOADER_EN
   logic [MEM_AW-1:0] ld_addr_q, ld_addr_d;
   logic [7:0]        ld_data_q, ld_data_d;
   logic              ld_ok_q, ld_ok_d;
   logic              load_oor;

   assign load_pending = load_req;
   assign load_oor     = {1'b0, load_addr} >= (ADDR_WIDTH + 1)'(MEM_DEPTH);
`else
   assign load_pending = 1'b0;
`endif

   // Misaligned or past the last full word: answered immediately without touching memory
   assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         asm_q   <= '0;
         instr_q <= '0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_EN
         ld_addr_q <= '0;
         ld_data_q <= '0;
         ld_ok_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         asm_q   <= asm_d;
         instr_q <= instr_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_EN
         ld_addr_q <= ld_addr_d;
         ld_data_q <= ld_data_d;
         ld_ok_q   <= ld_ok_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      asm_d       = asm_q;
      instr_d     = instr_q;
      err_d       = err_q;
      fetch_ready = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
`ifdef IMEM_LOADER_EN
      ld_addr_d = ld_addr_q;
      ld_data_d = ld_data_q;
      ld_ok_d   = ld_ok_q;
      load_ack  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            fetch_ready = !load_pending;
`ifdef IMEM_LOADER_EN
            if (load_req) begin
               state_d   = LOAD;
               ld_addr_d = load_addr[MEM_AW-1:0];
               ld_data_d = load_data;
               ld_ok_d   = !load_oor;
            end else
`endif
            if (fetch_req) begin
               if (fetch_bad) begin
                  state_d = RESP;
                  instr_d = NOP_INSTR;
                  err_d   = 1'b1;
               end else begin
                  state_d = ADDR;
                  cnt_d   = 2'd0;
                  base_d  = fetch_addr[MEM_AW-1:0];
               end
            end
         end

         ADDR: begin
            mem_addr = base_q + MEM_AW'(cnt_q);
            // Read data lags its address by one cycle, so cnt_q==k delivers byte k-1
            for (int k = 0; k < 3; k++) begin
               if (cnt_q == 2'(k + 1)) begin
                  asm_d[8*k +: 8] = mem_rdata;
               end
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = DRAIN;
            end
         end

         DRAIN: begin
            instr_d = {mem_rdata, asm_q};
            err_d   = 1'b0;
            state_d = RESP;
         end

         RESP: begin
            state_d = IDLE;
         end

`ifdef IMEM_LOADER_EN
         LOAD: begin
            mem_addr  = ld_addr_q;
            mem_we    = ld_ok_q;
            mem_wdata = ld_data_q;
            load_ack  = 1'b1;
            state_d   = IDLE;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fetch_valid = (state_q == RESP);
   assign fetch_instr = instr_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte-wide synchronous memory model.
// Loader scenarios run only when IMEM_LOADER_EN is defined.
module tb_imem_fetch_ctrl;

   localparam int AW    = 32;
   localparam int DEPTH = 2048;
   localparam int MAW   = 11;

   logic           clk = 1'b0;
   logic           rst;
   logic           fetch_req;
   logic [AW-1:0]  fetch_addr;
   logic           fetch_ready;
   logic           fetch_valid;
   logic [31:0]    fetch_instr;
   logic           fetch_err;
   logic [MAW-1:0] mem_addr;
   logic [7:0]     mem_rdata;
   logic           mem_we;
   logic [7:0]     mem_wdata;
`ifdef IMEM_LOADER_EN
   logic           load_req;
   logic [AW-1:0]  load_addr;
   logic [7:0]     load_data;
   logic           load_ack;
`endif

   logic [7:0] mem [0:DEPTH-1];
   int n_cmp   = 0;
   int n_bad   = 0;
   int we_seen = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(
      .ADDR_WIDTH(AW),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid),
      .fetch_instr(fetch_instr),
      .fetch_err  (fetch_err),
`ifdef IMEM_LOADER_EN
      .load_req   (load_req),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_ack   (load_ack),
`endif
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata)
   );

   // Memory model: preload while reset is high, synchronous read, byte write
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         mem[0]     <= 8'h93; mem[1]     <= 8'h00; mem[2]     <= 8'h50; mem[3]     <= 8'h00;
         mem[4]     <= 8'hEF; mem[5]     <= 8'hBE; mem[6]     <= 8'hAD; mem[7]     <= 8'hDE;
         mem[12'h7FC] <= 8'h11; mem[12'h7FD] <= 8'h22; mem[12'h7FE] <= 8'h33; mem[12'h7FF] <= 8'h44;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_we === 1'b1) we_seen++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_fetch(input logic [AW-1:0] addr, input logic [31:0] exp_instr, input logic exp_err);
      int lat;
      int exp_lat;
      exp_lat = exp_err ? 1 : 6;
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      #1;
      check_eq("ready", fetch_ready, 1);
      @(posedge clk); #1;
      fetch_req  = 1'b0;
      fetch_addr = 32'hFFFF_FFFF;
      lat = 1;
      while (fetch_valid !== 1'b1 && lat < 20) begin
         if (lat <= 4) check_eq("maddr", 32'(mem_addr), 32'(addr[MAW-1:0]) + 32'(lat - 1));
         @(posedge clk); #1;
         lat++;
      end
      check_eq("valid", fetch_valid, 1);
      check_eq("latency", lat, exp_lat);
      check_eq("instr", fetch_instr, exp_instr);
      check_eq("err", fetch_err, exp_err);
      check_eq("maddr_idle", 32'(mem_addr), 0);
      $display("fetch addr=%h instr=%h err=%b lat=%0d", addr, fetch_instr, fetch_err, lat);
      @(posedge clk); #1;
      check_eq("valid_pulse", fetch_valid, 0);
      check_eq("instr_hold", fetch_instr, exp_instr);
      check_eq("err_hold", fetch_err, exp_err);
      check_eq("ready_after", fetch_ready, 1);
   endtask

   initial begin
      int nvalid;
      int acc[$];
      int g0;
      int g1;
      rst        = 1'b1;
      fetch_req  = 1'b0;
      fetch_addr = '0;
`ifdef IMEM_LOADER_EN
      load_req  = 1'b0;
      load_addr = '0;
      load_data = '0;
`endif

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", fetch_valid, 0);
      check_eq("rst_instr", fetch_instr, 0);
      check_eq("rst_err", fetch_err, 0);
      check_eq("rst_maddr", 32'(mem_addr), 0);
      check_eq("rst_we", mem_we, 0);
      check_eq("rst_ready", fetch_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      do_fetch(32'h0000_0000, 32'h0050_0093, 1'b0);
      do_fetch(32'h0000_0004, 32'hDEAD_BEEF, 1'b0);
      do_fetch(32'h0000_0002, 32'h0000_0013, 1'b1);
      do_fetch(32'h0000_07FC, 32'h4433_2211, 1'b0);
      do_fetch(32'h0000_07FD, 32'h0000_0013, 1'b1);
      do_fetch(32'h0000_0800, 32'h0000_0013, 1'b1);

`ifdef IMEM_LOADER_EN
      // Load and fetch together: the load wins, fetch follows next cycle
      @(negedge clk);
      load_req   = 1'b1;
      load_addr  = 32'h10;
      load_data  = 8'hAB;
      fetch_req  = 1'b1;
      fetch_addr = 32'h10;
      #1;
      check_eq("ld_block_ready", fetch_ready, 0);
      @(posedge clk); #1;
      check_eq("ld_ack", load_ack, 1);
      check_eq("ld_we", mem_we, 1);
      check_eq("ld_maddr", 32'(mem_addr), 32'h10);
      check_eq("ld_wdata", mem_wdata, 8'hAB);
      check_eq("ld_ready", fetch_ready, 0);
      $display("load addr=%h data=%h ack=%b we=%b", load_addr, load_data, load_ack, mem_we);
      load_req = 1'b0;
      do_fetch(32'h0000_0010, 32'h0000_00AB, 1'b0);

      // Out-of-range load is acknowledged without a write
      @(negedge clk);
      load_req  = 1'b1;
      load_addr = 32'h900;
      load_data = 8'h5A;
      @(posedge clk); #1;
      check_eq("ldoor_ack", load_ack, 1);
      check_eq("ldoor_we", mem_we, 0);
      $display("load addr=%h data=%h ack=%b we=%b", load_addr, load_data, load_ack, mem_we);
      load_req = 1'b0;
      @(posedge clk); #1;
      check_eq("ldoor_ack_pulse", load_ack, 0);
`endif

      // Reset in the middle of a fetch discards it
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      @(posedge clk); #1;
      fetch_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("mid_rst_ready", fetch_ready, 1);
      check_eq("mid_rst_valid", fetch_valid, 0);
      check_eq("mid_rst_instr", fetch_instr, 0);
      check_eq("mid_rst_maddr", 32'(mem_addr), 0);
      nvalid = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (fetch_valid === 1'b1) nvalid++;
      end
      check_eq("mid_rst_no_resp", nvalid, 0);
      $display("reset mid-fetch: stray responses=%0d", nvalid);
      do_fetch(32'h0000_0000, 32'h0050_0093, 1'b0);

      // Continuous requests: acceptance spacing
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = 32'h4;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (fetch_ready === 1'b1) acc.push_back(c);
         @(negedge clk);
      end
      fetch_req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("b2b_count", acc.size(), 4);
      g0 = (acc.size() >= 2) ? acc[1] - acc[0] : 0;
      g1 = (acc.size() >= 3) ? acc[2] - acc[1] : 0;
      check_eq("b2b_gap0", g0, 7);
      check_eq("b2b_gap1", g1, 7);
      check_eq("b2b_instr", fetch_instr, 32'hDEAD_BEEF);
      $display("back-to-back accepts=%0d gaps=%0d,%0d", acc.size(), g0, g1);

`ifdef IMEM_LOADER_EN
      check_eq("we_total", we_seen, 1);
`else
      check_eq("we_total", we_seen, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
